// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: address/instruction widths,
// fetch state encoding and the instruction-memory legality check.
package fetch_stage_pkg;

    localparam int XLEN        = 64;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [XLEN:0]   addr_ext_t;   // one spare bit so pc+3 cannot wrap
    typedef logic [ILEN-1:0] instr_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    // Offset of the last byte of an instruction relative to its address.
    localparam addr_ext_t LAST_BYTE_OFS = addr_ext_t'(INSTR_BYTES - 1);

    // An address may be fetched when it is word aligned and the whole
    // instruction lies inside the memory. The sum is taken one bit wider so
    // addresses near 2^64 are not mistaken for small legal ones.
    function automatic logic addr_legal(input addr_t addr, input addr_ext_t mem_bytes);
        addr_ext_t last_byte;
        last_byte = {1'b0, addr} + LAST_BYTE_OFS;
        return (addr[1:0] == 2'b00) && (last_byte < mem_bytes);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect request from
// execute, and the IF/ID handshake towards decode.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    addr_t  imem_adr;
    instr_t imem_instr;
    logic   redirect;
    addr_t  redirect_pc;
    logic   id_ready;
    logic   if_valid;
    addr_t  if_pc;
    instr_t if_instr;

    // Seen from the fetch stage.
    modport master (
        output imem_adr,
        input  imem_instr,
        input  redirect,
        input  redirect_pc,
        input  id_ready,
        output if_valid,
        output if_pc,
        output if_instr
    );

    // Seen from the surrounding pipeline / memory.
    modport slave (
        input  imem_adr,
        output imem_instr,
        output redirect,
        output redirect_pc,
        output id_ready,
        input  if_valid,
        input  if_pc,
        input  if_instr
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats load beats drain; with none of them
// asserted the entry is held, which is how a decode stall is absorbed.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,      // capture a new instruction
    input  logic   flush,     // discard the entry (redirect)
    input  logic   drain,     // entry handed off with nothing to replace it
    input  addr_t  d_pc,
    input  instr_t d_instr,
    output logic   valid,
    output addr_t  q_pc,
    output instr_t q_instr
);

    logic   valid_reg;
    addr_t  pc_reg;
    instr_t instr_reg;

    // Entry storage with flush/load/drain priority; data is kept on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            pc_reg    <= '0;
            instr_reg <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            pc_reg    <= d_pc;
            instr_reg <= d_instr;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid   = valid_reg;
    assign q_pc    = pc_reg;
    assign q_instr = instr_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, BOOT/RUN/FAULT control, handoff
// counter, and the IF/ID register towards decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter addr_t RESET_PC  = 64'h0,
    parameter int    IMEM_SIZE = 256
)
(
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus,
    output logic          fault,
    output logic [31:0]   fetch_count
);

    localparam addr_ext_t MEM_BYTES = addr_ext_t'(IMEM_SIZE);

    fetch_state_t state_reg, state_next;
    addr_t        pc_reg, pc_next;
    logic [31:0]  fetch_count_reg;

    logic   if_valid_w;
    addr_t  if_pc_w;
    instr_t if_instr_w;

    logic advance;
    logic handoff;
    logic pc_legal;
    logic redirect_legal;
    logic load;
    logic flush;
    logic drain;
    logic count_inc;

    assign advance        = !if_valid_w || bus.id_ready;
    assign handoff        = if_valid_w && bus.id_ready;
    assign pc_legal       = addr_legal(pc_reg, MEM_BYTES);
    assign redirect_legal = addr_legal(bus.redirect_pc, MEM_BYTES);

    // State, pc and handoff counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= RESET_PC;
            fetch_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (count_inc) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
        end
    end

    // Next state, next pc and IF/ID control. A redirect wins over everything
    // and flushes the held entry without counting it. A held entry stays put
    // when the stage falls into FAULT and leaves only through a handoff.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        load       = 1'b0;
        flush      = 1'b0;
        drain      = 1'b0;
        count_inc  = 1'b0;
        unique case (state_reg)
            ST_BOOT: begin
                state_next = pc_legal ? ST_RUN : ST_FAULT;
            end
            ST_RUN: begin
                if (bus.redirect) begin
                    pc_next    = bus.redirect_pc;
                    flush      = 1'b1;
                    state_next = redirect_legal ? ST_RUN : ST_FAULT;
                end else if (!pc_legal) begin
                    state_next = ST_FAULT;
                    drain      = handoff;
                    count_inc  = handoff;
                end else if (advance) begin
                    load      = 1'b1;
                    pc_next   = pc_reg + addr_t'(INSTR_BYTES);
                    count_inc = handoff;
                end
            end
            ST_FAULT: begin
                if (bus.redirect) begin
                    pc_next    = bus.redirect_pc;
                    flush      = 1'b1;
                    state_next = redirect_legal ? ST_RUN : ST_FAULT;
                end else begin
                    drain     = handoff;
                    count_inc = handoff;
                end
            end
            default: begin
                state_next = ST_FAULT;
                flush      = 1'b1;
            end
        endcase
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .flush   (flush),
        .drain   (drain),
        .d_pc    (pc_reg),
        .d_instr (bus.imem_instr),
        .valid   (if_valid_w),
        .q_pc    (if_pc_w),
        .q_instr (if_instr_w)
    );

    assign bus.imem_adr = pc_reg;
    assign bus.if_valid = if_valid_w;
    assign bus.if_pc    = if_pc_w;
    assign bus.if_instr = if_instr_w;
    assign fault        = (state_reg == ST_FAULT);
    assign fetch_count  = fetch_count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect/reset traffic against a transaction-level reference model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [7:0] mem [0:255];

    fetch_stage_if bus ();      // main instance, 256-byte memory
    fetch_stage_if bus_s ();    // 16-byte memory
    fetch_stage_if bus_b ();    // misaligned reset pc

    logic        fault, fault_s, fault_b;
    logic [31:0] fcnt, fcnt_s, fcnt_b;

    fetch_stage #(.RESET_PC(64'h0), .IMEM_SIZE(256)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .fault(fault), .fetch_count(fcnt));
    fetch_stage #(.RESET_PC(64'h0), .IMEM_SIZE(16)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s), .fault(fault_s), .fetch_count(fcnt_s));
    fetch_stage #(.RESET_PC(64'h6), .IMEM_SIZE(256)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .fault(fault_b), .fetch_count(fcnt_b));

    // Little-endian instruction memories, one read port per instance.
    logic [7:0] ia, ia_s, ia_b;
    assign ia   = bus.imem_adr[7:0];
    assign ia_s = bus_s.imem_adr[7:0];
    assign ia_b = bus_b.imem_adr[7:0];
    assign bus.imem_instr   = (bus.imem_adr > 64'd252) ? 32'h0 :
                              {mem[ia+8'd3], mem[ia+8'd2], mem[ia+8'd1], mem[ia]};
    assign bus_s.imem_instr = (bus_s.imem_adr > 64'd252) ? 32'h0 :
                              {mem[ia_s+8'd3], mem[ia_s+8'd2], mem[ia_s+8'd1], mem[ia_s]};
    assign bus_b.imem_instr = (bus_b.imem_adr > 64'd252) ? 32'h0 :
                              {mem[ia_b+8'd3], mem[ia_b+8'd2], mem[ia_b+8'd1], mem[ia_b]};

    assign bus_s.redirect = 1'b0;
    assign bus_s.redirect_pc = '0;
    assign bus_s.id_ready = 1'b1;
    assign bus_b.redirect = 1'b0;
    assign bus_b.redirect_pc = '0;
    assign bus_b.id_ready = 1'b1;

    // Reference model of the main instance (mode 0 boot, 1 run, 2 fault).
    int          m_mode;
    logic [63:0] m_pc, m_ipc;
    logic        m_valid;
    logic [31:0] m_instr, m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [63:0] a);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < 4; k++) w = w | (32'(mem[8'(a + 64'(k))]) << (8 * k));
        return w;
    endfunction

    function automatic logic ref_legal(input logic [63:0] a, input logic [63:0] size);
        return (a % 64'd4 == 64'd0) && (a < size) && (size - a >= 64'd4);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = 64'h0; m_ipc = 64'h0;
        m_valid = 1'b0; m_instr = 32'h0; m_cnt = 32'h0;
    endtask

    // Advance the model by one clock using the currently driven inputs,
    // then let the DUT take the same edge and compare.
    task automatic step();
        logic hand;
        hand = m_valid && bus.id_ready;
        if (m_mode == 0) begin
            m_mode = ref_legal(m_pc, 64'd256) ? 1 : 2;
        end else if (bus.redirect) begin
            m_pc = bus.redirect_pc;
            m_valid = 1'b0;
            m_mode = ref_legal(bus.redirect_pc, 64'd256) ? 1 : 2;
        end else if (m_mode == 1 && !ref_legal(m_pc, 64'd256)) begin
            m_mode = 2;
            if (hand) begin m_valid = 1'b0; m_cnt++; end
        end else if (m_mode == 1 && (!m_valid || bus.id_ready)) begin
            if (hand) m_cnt++;
            m_ipc = m_pc;
            m_instr = ref_word(m_pc);
            m_valid = 1'b1;
            m_pc = m_pc + 64'd4;
        end else if (m_mode == 2 && hand) begin
            m_valid = 1'b0;
            m_cnt++;
        end
        @(posedge clk);
        #1;
        check_eq("imem_adr", bus.imem_adr, m_pc);
        check_eq("if_valid", 64'(bus.if_valid), 64'(m_valid));
        if (m_valid) begin
            check_eq("if_pc", bus.if_pc, m_ipc);
            check_eq("if_instr", 64'(bus.if_instr), 64'(m_instr));
        end
        check_eq("fault", 64'(fault), 64'(m_mode == 2));
        check_eq("fetch_count", 64'(fcnt), 64'(m_cnt));
        $display("cyc t=%0t adr=0x%0h v=%0b if_pc=0x%0h fault=%0b cnt=%0d",
                 $time, bus.imem_adr, bus.if_valid, bus.if_pc, fault, fcnt);
    endtask

    // Assert reset between edges and check outputs before any edge arrives.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_imem_adr", bus.imem_adr, 64'h0);
        check_eq("rst_if_valid", 64'(bus.if_valid), 64'h0);
        check_eq("rst_if_pc", bus.if_pc, 64'h0);
        check_eq("rst_if_instr", 64'(bus.if_instr), 64'h0);
        check_eq("rst_fault", 64'(fault), 64'h0);
        check_eq("rst_fetch_count", 64'(fcnt), 64'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] cnt_before;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready = 1'b1;
        model_reset();

        // Straight-line fetch; the small and misaligned instances run alongside.
        apply_reset();
        check_eq("boot_fault_b_pre", 64'(fault_b), 64'h0);
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) begin
                check_eq("boot_fault_b", 64'(fault_b), 64'h1);
                check_eq("boot_adr_b", bus_b.imem_adr, 64'h6);
                check_eq("boot_valid_b", 64'(bus_b.if_valid), 64'h0);
                check_eq("boot_valid", 64'(bus.if_valid), 64'h0);
            end
            if (i == 2) check_eq("first_instr", 64'(bus.if_instr), 64'(ref_word(64'h0)));
            if (i == 5) check_eq("small_last_pc", bus_s.if_pc, 64'd12);
            if (i == 6) begin
                check_eq("small_fault", 64'(fault_s), 64'h1);
                check_eq("small_adr", bus_s.imem_adr, 64'd16);
                check_eq("small_count", 64'(fcnt_s), 64'd4);
                check_eq("seq_count", 64'(fcnt), 64'd4);
            end
        end

        // Decode stall while the entry at 4 is held.
        apply_reset();
        for (int i = 0; i < 3; i++) step();
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_if_pc", bus.if_pc, 64'd4);
            check_eq("stall_adr", bus.imem_adr, 64'd8);
        end
        bus.id_ready = 1'b1;
        step();
        check_eq("stall_release_pc", bus.if_pc, 64'd8);

        // Redirect while stalled with a valid entry: flush, not counted.
        bus.id_ready = 1'b0;
        cnt_before = m_cnt;
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h0;
        step();
        check_eq("flush_valid", 64'(bus.if_valid), 64'h0);
        check_eq("flush_adr", bus.imem_adr, 64'h0);
        check_eq("flush_count", 64'(fcnt), 64'(cnt_before));

        // Misaligned redirect faults; a legal one recovers.
        bus.redirect_pc = 64'h6;
        step();
        check_eq("bad_redir_fault", 64'(fault), 64'h1);
        check_eq("bad_redir_valid", 64'(bus.if_valid), 64'h0);
        bus.redirect_pc = 64'h0;
        step();
        check_eq("recover_fault", 64'(fault), 64'h0);
        bus.redirect = 1'b0;
        bus.id_ready = 1'b1;
        step();
        check_eq("recover_valid", 64'(bus.if_valid), 64'h1);
        check_eq("recover_instr", 64'(bus.if_instr), 64'(ref_word(64'h0)));

        // Randomized traffic with occasional mid-stream resets.
        for (int c = 0; c < 3000; c++) begin
            bus.id_ready = ($urandom_range(0, 9) < 7);
            bus.redirect = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: bus.redirect_pc = 64'($urandom_range(0, 63)) * 64'd4;
                6: bus.redirect_pc = 64'($urandom_range(0, 63)) * 64'd4 + 64'($urandom_range(1, 3));
                7: bus.redirect_pc = 64'd252;
                8: bus.redirect_pc = 64'd256;
                default: bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
            endcase
            step();
            if ($urandom_range(0, 199) == 0) apply_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_SIZE, default 256, the instruction memory size in bytes; legal fetch when pc+3 < IMEM_SIZE.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 imem_adr  out  64  byte address to the instruction memory, equal to pc (combinational).
REQ-007 imem_instr  in  32  little-endian instruction word returned combinationally for imem_adr.
REQ-008 redirect  in  1  branch/jump taken this cycle.
REQ-009 redirect_pc  in  64  target byte address when redirect=1.
REQ-010 id_ready  in  1  decode stage accepts the IF/ID contents this cycle.
REQ-011 if_valid  out  1  IF/ID register holds a valid instruction.
REQ-012 if_pc  out  64  address of the held instruction.
REQ-013 if_instr  out  32  held instruction word.
REQ-014 fault  out  1  high while in FAULT state.
REQ-015 fetch_count  out  32  number of instructions handed to decode.

Function
REQ-016 SHALL implement states BOOT, RUN, FAULT; BOOT lasts exactly one cycle after reset release, then goes to RUN.
REQ-017 IF/ID "advance" SHALL be defined as (!if_valid || id_ready).
REQ-018 In RUN, on advance with a legal pc and no redirect: IF/ID loads {pc, imem_instr}, if_valid<=1, pc<=pc+4 (64-bit wrap).
REQ-019 In RUN, when advance=0 and redirect=0: pc and IF/ID hold unchanged; no imem word is dropped or duplicated.
REQ-020 Handoff SHALL occur on a cycle with if_valid=1 and id_ready=1; fetch_count increments by 1 on each handoff and wraps at 2^32.
REQ-021 redirect SHALL take priority over stall and advance: pc<=redirect_pc, if_valid<=0 (flush) in the same edge, regardless of id_ready; the flushed entry is not counted.
REQ-022 A redirect with redirect_pc[1:0]!=0 or redirect_pc+3 >= IMEM_SIZE SHALL enter FAULT with pc<=redirect_pc and if_valid<=0.
REQ-023 Sequential pc reaching an illegal range (pc+3 >= IMEM_SIZE) SHALL enter FAULT instead of fetching; the IF/ID entry, if still held, is retained until handed off.
REQ-024 In FAULT: fault=1, no fetches, pc frozen; only a legal redirect returns to RUN with pc<=redirect_pc; an illegal redirect stays in FAULT with updated pc.
REQ-025 Fetch-to-if_valid latency SHALL be one cycle; the first instruction appears with if_valid=1 two edges after reset release (BOOT plus one RUN edge).
REQ-026 imem_instr SHALL be sampled only on edges where IF/ID loads; never in BOOT or FAULT.

Reset
REQ-027 On rst_n=0 (asynchronous): state=BOOT, pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0, fault=0, fetch_count=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; no handoff is counted on the reset edge.
REQ-029 RESET_PC illegal per REQ-022 SHALL cause BOOT to go to FAULT rather than RUN.

Structure
REQ-030 State encoding, INSTR_BYTES=4 and the address width 64 SHALL live in the shared cpu package.
REQ-031 The IF/ID register with hold/flush SHALL be a sub-module named if_id_reg; the pc, state machine and counter remain in fetch_stage.

Verification
REQ-032 Reset release, imem holds words at 0,4,8,12, id_ready=1 -> if_instr = word@0, word@4, word@8, word@12 on consecutive cycles, if_pc=0,4,8,12, fetch_count=4.
REQ-033 id_ready=0 for 3 cycles while if_pc=4 -> if_pc/if_instr stay 4/word@4 and imem_adr stays 8; after release, if_pc=8 follows with no gap or repeat.
REQ-034 redirect=1, redirect_pc=0 while id_ready=0 and if_valid=1 -> next cycle if_valid=0, imem_adr=0, fetch_count unchanged.
REQ-035 redirect_pc=64'h6 -> fault=1, if_valid=0; then redirect_pc=0 -> fault=0 and word@0 delivered one cycle later.
REQ-036 IMEM_SIZE=16, run sequentially from 0 -> four instructions delivered, then fault=1 with imem_adr=16 and fetch_count=4.
REQ-037 rst_n pulsed low mid-stream -> all outputs return to reset values immediately, with no clock edge required.
